// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, word width and FSM state encodings for the fetch controller.
// The FAULT state only exists when FETCH_MISALIGN_CHK_EN is defined.
package fetch_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b0;
  localparam logic ENABLE     = 1'b1;
  localparam logic DISABLE    = 1'b0;

  localparam int               WORD_W    = 32;
  localparam logic [WORD_W-1:0] ZERO_WORD = '0;
  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
`ifdef FETCH_MISALIGN_CHK_EN
    , ST_FAULT = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller (master) and its bus/downstream/control side (slave).
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic              hold_i;
  logic              jump_i;
  logic [WORD_W-1:0] jump_addr_i;
  logic              req_valid_o;
  logic              req_ready_i;
  logic [WORD_W-1:0] req_addr_o;
  logic              rsp_valid_i;
  logic [WORD_W-1:0] rsp_data_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [WORD_W-1:0] inst_pc_o;
  logic [WORD_W-1:0] inst_data_o;
  logic              misalign_o;

  modport master (
    input  hold_i, jump_i, jump_addr_i, req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i,
    output req_valid_o, req_addr_o, inst_valid_o, inst_pc_o, inst_data_o, misalign_o
  );

  modport slave (
    output hold_i, jump_i, jump_addr_i, req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i,
    input  req_valid_o, req_addr_o, inst_valid_o, inst_pc_o, inst_data_o, misalign_o
  );

endinterface

// File: rtl/fetch_ctrl_fifo.sv
// fetch_fifo: small synchronous FIFO with registered head, occupancy count and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues tagged instruction reads and queues returned {pc,inst}.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned jump targets instead of truncating them.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2,
  parameter int                CNT_W    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  localparam int OCC_W = CNT_W + 1;
  localparam int QW    = 2 * WORD_W;

  state_t            state;
  logic [WORD_W-1:0] pc;
  logic              req_valid;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  inflight_next;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  q_count_next;
  logic [CNT_W-1:0]  tag_count;
  logic [OCC_W-1:0]  occ_next;
  logic [WORD_W-1:0] tag_head;
  logic [WORD_W-1:0] jump_target;
  logic [QW-1:0]     q_head;
  logic              accept;
  logic              rsp_drop;
  logic              rsp_keep;
  logic              q_pop;
  logic              good_jump;
  logic              can_issue;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign;
  logic bad_jump;
  assign bad_jump       = bus.jump_i && (bus.jump_addr_i[1:0] != 2'b00);
  assign good_jump      = bus.jump_i && !bad_jump;
  assign jump_target    = bus.jump_addr_i;
  assign can_issue      = !bus.hold_i && (state != ST_FAULT);
  assign bus.misalign_o = misalign;
`else
  assign good_jump      = bus.jump_i;
  assign jump_target    = bus.jump_addr_i & ~32'h3;
  assign can_issue      = !bus.hold_i;
  assign bus.misalign_o = DISABLE;
`endif

  assign accept   = req_valid && bus.req_ready_i;
  assign rsp_drop = bus.rsp_valid_i && (discard != '0);
  assign rsp_keep = bus.rsp_valid_i && (discard == '0);
  assign q_pop    = bus.inst_valid_o && bus.inst_ready_i;

  // Occupancy one cycle ahead keeps in-flight plus queued reads within DEPTH
  assign inflight_next = inflight + CNT_W'(accept) - CNT_W'(bus.rsp_valid_i);
  assign q_count_next  = q_count + CNT_W'(rsp_keep) - CNT_W'(q_pop);
  assign occ_next      = OCC_W'(inflight_next) + OCC_W'(q_count_next);

  assign bus.req_valid_o  = req_valid;
  assign bus.req_addr_o   = pc;
  assign bus.inst_valid_o = (q_count != '0);
  assign bus.inst_pc_o    = q_head[QW-1:WORD_W];
  assign bus.inst_data_o  = q_head[WORD_W-1:0];

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W), .CNT_W(CNT_W)) u_tag_fifo (
    .clk(clk), .rst_n(rst_n), .push(accept), .pop(rsp_keep), .flush(bus.jump_i),
    .push_data(pc), .head(tag_head), .count(tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(QW), .CNT_W(CNT_W)) u_out_q (
    .clk(clk), .rst_n(rst_n), .push(rsp_keep), .pop(q_pop), .flush(bus.jump_i),
    .push_data({tag_head, bus.rsp_data_i}), .head(q_head), .count(q_count)
  );

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_valid <= DISABLE;
      inflight  <= '0;
      discard   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign  <= DISABLE;
`endif
    end else begin
      inflight <= inflight_next;
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: if (bus.hold_i) state <= ST_STALL;
        ST_STALL: if (!bus.hold_i) state <= ST_FETCH;
`ifdef FETCH_MISALIGN_CHK_EN
        ST_FAULT: if (good_jump) state <= bus.hold_i ? ST_STALL : ST_FETCH;
`endif
        default:  state <= ST_IDLE;
      endcase
      // Reads still outstanding after a redirect (including one accepted now) are stale
      if (bus.jump_i) begin
        req_valid <= DISABLE;
        discard   <= inflight_next;
        if (good_jump) pc <= jump_target;
      end else begin
        if (rsp_drop) discard <= discard - CNT_W'(1);
        if (accept) pc <= pc + PC_STEP;
        if (!req_valid || bus.req_ready_i)
          req_valid <= can_issue && (occ_next < OCC_W'(DEPTH));
      end
`ifdef FETCH_MISALIGN_CHK_EN
      if (bad_jump) begin
        state    <= ST_FAULT;
        misalign <= ENABLE;
      end else if (good_jump) begin
        misalign <= DISABLE;
      end
`endif
    end
  end

  a_rsp_has_inflight: assert property (@(posedge clk) disable iff (rst_n == RST_ENABLE)
    bus.rsp_valid_i |-> (inflight != '0));
  a_rsp_has_tag: assert property (@(posedge clk) disable iff (rst_n == RST_ENABLE)
    rsp_keep |-> (tag_count != '0));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: a bus model answers each accepted read one cycle later.
// Covers reset, sequential fetch, request stall, back-pressure, jump flush, hold, wrap, jump alignment.
module tb_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   rsp_gate;
  logic [31:0] bus_a;
  logic [31:0] acc_log[$];
  logic [31:0] pend[$];
  logic [31:0] inst_pc_log[$];
  logic [31:0] inst_data_log[$];

  fetch_ctrl_if bus_if();

  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] acc_at(input int k);
    return (k < acc_log.size()) ? acc_log[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ipc_at(input int k);
    return (k < inst_pc_log.size()) ? inst_pc_log[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] idata_at(input int k);
    return (k < inst_data_log.size()) ? inst_data_log[k] : 32'hDEAD_BEEF;
  endfunction

  // Bus model and monitor run just after the falling edge, once test inputs have settled
  initial begin
    forever begin
      @(negedge clk);
      #1;
      bus_if.rsp_valid_i = 1'b0;
      if (rst_n === 1'b1) begin
        if (rsp_gate && pend.size() > 0) begin
          bus_a = pend.pop_front();
          bus_if.rsp_valid_i = 1'b1;
          bus_if.rsp_data_i  = inst_word(bus_a);
        end
        if (bus_if.req_valid_o && bus_if.req_ready_i) begin
          pend.push_back(bus_if.req_addr_o);
          acc_log.push_back(bus_if.req_addr_o);
        end
        if (bus_if.inst_valid_o && bus_if.inst_ready_i) begin
          inst_pc_log.push_back(bus_if.inst_pc_o);
          inst_data_log.push_back(bus_if.inst_data_o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.hold_i = 1'b0;
    bus_if.jump_i = 1'b0;
    bus_if.jump_addr_i = 32'h0;
    bus_if.req_ready_i = 1'b0;
    bus_if.inst_ready_i = 1'b0;
    bus_if.rsp_valid_i = 1'b0;
    bus_if.rsp_data_i = 32'h0;
    rsp_gate = 1'b1;
    repeat (3) @(negedge clk);
    acc_log.delete();
    pend.delete();
    inst_pc_log.delete();
    inst_data_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = (acc_log.size() >= n);
    end
  endtask

  task automatic wait_inst(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = (inst_pc_log.size() >= n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %0h expected 0", bus_if.req_valid_o); end
    checks++; if (bus_if.req_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_req_addr: got %0h expected 0", bus_if.req_addr_o); end
    checks++; if (bus_if.inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %0h expected 0", bus_if.inst_valid_o); end
    checks++; if (bus_if.inst_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc: got %0h expected 0", bus_if.inst_pc_o); end
    checks++; if (bus_if.inst_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_data: got %0h expected 0", bus_if.inst_data_o); end
    checks++; if (bus_if.misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %0h expected 0", bus_if.misalign_o); end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] exp_acc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    bus_if.req_ready_i = 1'b1;
    bus_if.inst_ready_i = 1'b1;
    wait_inst(3, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL seq_wait: got %0d insts expected 3", inst_pc_log.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (acc_at(k) !== exp_acc[k]) begin errors++; $display("[TB] FAIL seq_req_addr[%0d]: got %0h expected %0h", k, acc_at(k), exp_acc[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ipc_at(k) !== exp_acc[k]) begin errors++; $display("[TB] FAIL seq_inst_pc[%0d]: got %0h expected %0h", k, ipc_at(k), exp_acc[k]); end
      checks++; if (idata_at(k) !== inst_word(exp_acc[k])) begin errors++; $display("[TB] FAIL seq_inst_data[%0d]: got %0h expected %0h", k, idata_at(k), inst_word(exp_acc[k])); end
    end
  endtask

  task automatic test_req_stall();
    bit ok;
    do_reset();
    bus_if.req_ready_i = 1'b1;
    bus_if.inst_ready_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus_if.req_valid_o && (bus_if.req_addr_o == 32'h8);
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_reach_8: got %0h expected 8", bus_if.req_addr_o); end
    bus_if.req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_if.req_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %0h expected 1", i, bus_if.req_valid_o); end
      checks++; if (bus_if.req_addr_o !== 32'h8) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got %0h expected 8", i, bus_if.req_addr_o); end
      @(negedge clk);
    end
    checks++; if (acc_log.size() !== 2) begin errors++; $display("[TB] FAIL stall_no_accept: got %0d expected 2", acc_log.size()); end
    bus_if.req_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (acc_at(2) !== 32'h8) begin errors++; $display("[TB] FAIL stall_accept: got %0h expected 8", acc_at(2)); end
    wait_acc(4, ok);
    checks++; if (acc_at(3) !== 32'hC) begin errors++; $display("[TB] FAIL stall_next: got %0h expected c", acc_at(3)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_if.req_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (acc_log.size() !== 2) begin errors++; $display("[TB] FAIL bp_accepts: got %0d expected 2", acc_log.size()); end
    checks++; if (bus_if.req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_valid: got %0h expected 0", bus_if.req_valid_o); end
    checks++; if (bus_if.inst_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_inst_valid: got %0h expected 1", bus_if.inst_valid_o); end
    checks++; if (bus_if.inst_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL bp_head_pc: got %0h expected 0", bus_if.inst_pc_o); end
    checks++; if (bus_if.inst_data_o !== inst_word(32'h0)) begin errors++; $display("[TB] FAIL bp_head_data: got %0h expected %0h", bus_if.inst_data_o, inst_word(32'h0)); end
    bus_if.inst_ready_i = 1'b1;
    @(negedge clk);
    bus_if.inst_ready_i = 1'b0;
    checks++; if (bus_if.req_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_valid: got %0h expected 1", bus_if.req_valid_o); end
    checks++; if (bus_if.req_addr_o !== 32'h8) begin errors++; $display("[TB] FAIL bp_resume_addr: got %0h expected 8", bus_if.req_addr_o); end
    checks++; if (bus_if.inst_pc_o !== 32'h4) begin errors++; $display("[TB] FAIL bp_next_head: got %0h expected 4", bus_if.inst_pc_o); end
    @(negedge clk);
    checks++; if (acc_at(2) !== 32'h8) begin errors++; $display("[TB] FAIL bp_third_accept: got %0h expected 8", acc_at(2)); end
  endtask

  task automatic test_jump();
    bit ok;
    do_reset();
    bus_if.req_ready_i = 1'b1;
    bus_if.inst_ready_i = 1'b1;
    rsp_gate = 1'b0;
    bus_if.jump_i = 1'b1;
    bus_if.jump_addr_i = 32'h10;
    @(negedge clk);
    bus_if.jump_i = 1'b0;
    wait_acc(2, ok);
    checks++; if (acc_at(0) !== 32'h10 || acc_at(1) !== 32'h14) begin errors++; $display("[TB] FAIL jump_inflight: got %0h,%0h expected 10,14", acc_at(0), acc_at(1)); end
    checks++; if (bus_if.req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL jump_full: got %0h expected 0", bus_if.req_valid_o); end
    bus_if.jump_i = 1'b1;
    bus_if.jump_addr_i = 32'h100;
    @(negedge clk);
    bus_if.jump_i = 1'b0;
    rsp_gate = 1'b1;
    checks++; if (bus_if.req_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL jump_addr: got %0h expected 100", bus_if.req_addr_o); end
    checks++; if (bus_if.inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL jump_inst_valid: got %0h expected 0", bus_if.inst_valid_o); end
    wait_inst(1, ok);
    checks++; if (ipc_at(0) !== 32'h100) begin errors++; $display("[TB] FAIL jump_first_pc: got %0h expected 100", ipc_at(0)); end
    checks++; if (idata_at(0) !== inst_word(32'h100)) begin errors++; $display("[TB] FAIL jump_first_data: got %0h expected %0h", idata_at(0), inst_word(32'h100)); end
  endtask

  task automatic test_hold();
    bit ok;
    do_reset();
    bus_if.req_ready_i = 1'b1;
    bus_if.inst_ready_i = 1'b1;
    rsp_gate = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (acc_log.size() >= 2) && !bus_if.req_valid_o;
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_setup: got %0d accepts expected 2", acc_log.size()); end
    bus_if.hold_i = 1'b1;
    rsp_gate = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_if.req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %0h expected 0", i, bus_if.req_valid_o); end
    end
    bus_if.hold_i = 1'b0;
    @(negedge clk);
    checks++; if (acc_log.size() !== 2) begin errors++; $display("[TB] FAIL hold_accepts: got %0d expected 2", acc_log.size()); end
    checks++; if (ipc_at(0) !== 32'h0 || ipc_at(1) !== 32'h4) begin errors++; $display("[TB] FAIL hold_drain: got %0h,%0h expected 0,4", ipc_at(0), ipc_at(1)); end
    checks++; if (bus_if.req_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL hold_resume_valid: got %0h expected 1", bus_if.req_valid_o); end
    checks++; if (bus_if.req_addr_o !== 32'h8) begin errors++; $display("[TB] FAIL hold_resume_addr: got %0h expected 8", bus_if.req_addr_o); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    bus_if.req_ready_i = 1'b1;
    bus_if.inst_ready_i = 1'b1;
    bus_if.jump_i = 1'b1;
    bus_if.jump_addr_i = 32'hFFFF_FFFC;
    @(negedge clk);
    bus_if.jump_i = 1'b0;
    wait_inst(2, ok);
    checks++; if (acc_at(0) !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_first: got %0h expected fffffffc", acc_at(0)); end
    checks++; if (acc_at(1) !== 32'h0) begin errors++; $display("[TB] FAIL wrap_second: got %0h expected 0", acc_at(1)); end
    checks++; if (ipc_at(1) !== 32'h0) begin errors++; $display("[TB] FAIL wrap_inst_pc: got %0h expected 0", ipc_at(1)); end
  endtask

  task automatic test_jump_align();
    do_reset();
    bus_if.req_ready_i = 1'b1;
    bus_if.inst_ready_i = 1'b1;
    bus_if.jump_i = 1'b1;
    bus_if.jump_addr_i = 32'h102;
    @(negedge clk);
    bus_if.jump_i = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_if.misalign_o !== 1'b1) begin errors++; $display("[TB] FAIL mis_flag[%0d]: got %0h expected 1", i, bus_if.misalign_o); end
      checks++; if (bus_if.req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_req[%0d]: got %0h expected 0", i, bus_if.req_valid_o); end
      @(negedge clk);
    end
    bus_if.jump_i = 1'b1;
    bus_if.jump_addr_i = 32'h200;
    @(negedge clk);
    bus_if.jump_i = 1'b0;
    checks++; if (bus_if.misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %0h expected 0", bus_if.misalign_o); end
    @(negedge clk);
    checks++; if (bus_if.req_valid_o !== 1'b1 || bus_if.req_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL mis_refetch: got %0h@%0h expected 1@200", bus_if.req_valid_o, bus_if.req_addr_o); end
`else
    checks++; if (bus_if.req_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL align_addr: got %0h expected 100", bus_if.req_addr_o); end
    checks++; if (bus_if.misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL align_misalign: got %0h expected 0", bus_if.misalign_o); end
    @(negedge clk);
    checks++; if (bus_if.req_valid_o !== 1'b1 || bus_if.req_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL align_fetch: got %0h@%0h expected 1@100", bus_if.req_valid_o, bus_if.req_addr_o); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rsp_gate = 1'b1;
    test_reset();
    test_sequential();
    test_req_stall();
    test_backpressure();
    test_jump();
    test_hold();
    test_wrap();
    test_jump_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
